lenet_batch_ctrl: RTL

- Sequencer in front of lenet_top: launches one LeNet inference per stored test image, waits for completion, checks the predicted class against a label ROM, and keeps running accuracy statistics.
- Supports single-image mode (graph chosen on switches) and batch mode (all images 0..NUM_GRAPHS-1 back to back).
- Drives the lenet_top start/graph inputs and feeds the 7-segment scan logic with the latest graph/result pair.

---
 rtl/lenet_batch_ctrl_if.sv | 23 ++
 rtl/lenet_batch_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lenet_batch_ctrl_if.sv
// Handshake bundle between the batch sequencer, lenet_top and the label ROM.
// The sequencer is the master: it drives the addresses and the start pulse.
interface lenet_batch_ctrl_if #(
    parameter int GRAPH_W = 5,
    parameter int IDX_W   = 4
);
    logic [GRAPH_W-1:0] label_addr;
    logic [IDX_W-1:0]   label_data;
    logic               lenet_start;
    logic [GRAPH_W-1:0] lenet_graph;
    logic               lenet_finish;
    logic [IDX_W-1:0]   lenet_max_index;

    modport master (
        output label_addr, lenet_start, lenet_graph,
        input  label_data, lenet_finish, lenet_max_index
    );

    modport slave (
        input  label_addr, lenet_start, lenet_graph,
        output label_data, lenet_finish, lenet_max_index
    );
endinterface

// File: rtl/lenet_batch_ctrl.sv
// Inference sequencer: launches lenet_top once per image, scores the result
// against the label ROM and keeps per-run completion/accuracy counters.
module lenet_batch_ctrl #(
    parameter int NUM_GRAPHS  = 20,
    parameter int GRAPH_W     = 5,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TO_W        = 24
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               run_req,
    input  logic               abort,
    input  logic               mode_batch,
    input  logic [GRAPH_W-1:0] graph_sel,
    lenet_batch_ctrl_if.master bus,
    output logic [GRAPH_W-1:0] disp_graph,
    output logic [IDX_W-1:0]   disp_index,
    output logic               disp_valid,
    output logic [5:0]         correct_cnt,
    output logic [5:0]         done_cnt,
    output logic               busy,
    output logic               batch_done,
    output logic               timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_LAUNCH, S_WAIT, S_CHECK, S_WAITLOW, S_DONE
    } state_t;

    localparam logic [GRAPH_W-1:0] LAST_GRAPH = GRAPH_W'(NUM_GRAPHS - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]   TO_INDEX   = '1;

    state_t             state_reg, state_next;
    logic               run_req_d_reg;
    logic [GRAPH_W-1:0] cur_graph_reg, cur_graph_next;
    logic               mode_reg;
    logic [IDX_W-1:0]   exp_label_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [GRAPH_W-1:0] disp_graph_reg;
    logic [IDX_W-1:0]   disp_index_reg;
    logic               timeout_err_reg;

    logic run_edge, in_busy, start_run, to_hit, check_enter, advance, match;
    logic [1:0] cnt_inc;

    assign run_edge    = run_req & ~run_req_d_reg;
    assign in_busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign start_run   = !in_busy && run_edge;
    assign to_hit      = (to_cnt_reg == TO_LAST);
    assign check_enter = (state_reg == S_WAIT) && (state_next == S_CHECK);
    assign advance     = (state_reg == S_CHECK) && (state_next == S_WAITLOW);
    assign match       = bus.lenet_finish && (bus.lenet_max_index == exp_label_reg);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: if (run_edge) state_next = S_PREP;
            S_PREP:         state_next = S_LAUNCH;
            S_LAUNCH:       state_next = S_WAIT;
            S_WAIT:         if (bus.lenet_finish || to_hit) state_next = S_CHECK;
            S_CHECK: begin
                if (!mode_reg || cur_graph_reg == LAST_GRAPH) state_next = S_DONE;
                else                                          state_next = S_WAITLOW;
            end
            S_WAITLOW:      if (!bus.lenet_finish) state_next = S_PREP;
            default:        state_next = S_IDLE;
        endcase
        // Abort wins over finish and timeout, so an aborted image never reaches CHECK.
        if (in_busy && abort) state_next = S_IDLE;
    end

    always_comb begin
        busy            = in_busy;
        batch_done      = (state_reg == S_DONE);
        bus.lenet_start = (state_reg == S_LAUNCH) && !abort;
        disp_valid      = (state_reg == S_CHECK);
    end

    always_comb begin
        cur_graph_next = cur_graph_reg;
        if (start_run) begin
            if (mode_batch)                    cur_graph_next = '0;
            else if (graph_sel > LAST_GRAPH)   cur_graph_next = LAST_GRAPH;
            else                               cur_graph_next = graph_sel;
        end else if (advance) begin
            cur_graph_next = cur_graph_reg + GRAPH_W'(1);
        end
    end

    // Results are registered on the WAIT->CHECK edge so disp_* and the
    // counters are already current while disp_valid is high.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            run_req_d_reg   <= 1'b0;
            cur_graph_reg   <= '0;
            mode_reg        <= 1'b0;
            exp_label_reg   <= '0;
            to_cnt_reg      <= '0;
            disp_graph_reg  <= '0;
            disp_index_reg  <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            run_req_d_reg <= run_req;
            cur_graph_reg <= cur_graph_next;
            if (start_run) begin
                mode_reg        <= mode_batch;
                timeout_err_reg <= 1'b0;
            end
            if (state_reg == S_LAUNCH) begin
                exp_label_reg <= bus.label_data;
                to_cnt_reg    <= '0;
            end else if (state_reg == S_WAIT) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
            if (check_enter) begin
                disp_graph_reg <= cur_graph_reg;
                if (bus.lenet_finish) begin
                    disp_index_reg <= bus.lenet_max_index;
                end else begin
                    disp_index_reg  <= TO_INDEX;
                    timeout_err_reg <= 1'b1;
                end
            end
        end
    end

    assign cnt_inc[0] = check_enter;
    assign cnt_inc[1] = check_enter && match;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [5:0] cnt_reg;
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) begin
                    cnt_reg <= '0;
                end else if (start_run) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && cnt_reg != 6'd63) begin
                    cnt_reg <= cnt_reg + 6'd1;
                end
            end
        end
    endgenerate

    assign done_cnt        = g_cnt[0].cnt_reg;
    assign correct_cnt     = g_cnt[1].cnt_reg;
    assign bus.label_addr  = cur_graph_reg;
    assign bus.lenet_graph = cur_graph_reg;
    assign disp_graph      = disp_graph_reg;
    assign disp_index      = disp_index_reg;
    assign timeout_err     = timeout_err_reg;
endmodule
